qam_demapper: RTL

Receive-side 16-QAM hard-decision demapper: the inverse of the modulator's bit-to-symbol mapping. It sits after the demodulator's low-pass filters. It slices filtered 8-bit I/Q samples into 2-bit Gray-coded levels and buffers each 4-bit symbol in a small FIFO. It then replays the symbols as a serial bit stream, one bit per downstream request. Overflow and underflow are reported through sticky flags.

---
 rtl/qam_demapper_if.sv | 31 +++
 rtl/qam_demapper.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/qam_demapper_if.sv
// Demapper sample/bit-stream bundle.
// The master side supplies filtered samples and bit requests. The slave side
// (the demapper) returns the serial bit stream, the slicer levels and status.
interface qam_demapper_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              sym_valid;
    logic [DATA_W-1:0] filt_i;
    logic [DATA_W-1:0] filt_q;
    logic              bit_req;
    logic              signal;
    logic              signal_valid;
    logic [1:0]        sym_i;
    logic [1:0]        sym_q;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
    logic              underflow;

    modport master (
        output sym_valid, filt_i, filt_q, bit_req,
        input  signal, signal_valid, sym_i, sym_q, fifo_level, overflow, underflow
    );

    modport slave (
        input  sym_valid, filt_i, filt_q, bit_req,
        output signal, signal_valid, sym_i, sym_q, fifo_level, overflow, underflow
    );
endinterface

// File: rtl/qam_demapper.sv
// 16-QAM hard-decision demapper.
// Slices each I/Q sample into a Gray-coded 2-bit level per axis, queues the
// resulting nibble in a small FIFO and replays it MSB first, one bit per
// request. Dropped symbols and starved requests raise sticky flags.
module qam_demapper #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned THRESH     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk_signal,
    input  logic           rst_n,
    qam_demapper_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam int signed              THRESH_S = THRESH;
    localparam logic signed [DATA_W-1:0] THR_POS = DATA_W'(THRESH_S);
    localparam logic signed [DATA_W-1:0] THR_NEG = DATA_W'(-THRESH_S);

    // Gray-coded level: adjacent decision regions differ in one bit.
    function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] v);
        logic [1:0] lvl;
        if (v < THR_NEG) begin
            lvl = 2'b00;
        end else if (v[DATA_W-1]) begin
            lvl = 2'b01;
        end else if (v < THR_POS) begin
            lvl = 2'b11;
        end else begin
            lvl = 2'b10;
        end
        return lvl;
    endfunction

    // Storage and state
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       sym_i_q, sym_i_d;
    logic [1:0]       sym_q_q, sym_q_d;
    logic [1:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       shift_q, shift_d;
    logic             signal_q, signal_d;
    logic             signal_valid_q, signal_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic [1:0] lvl_i, lvl_q;
    logic [3:0] nibble;
    logic [3:0] head;
    logic       ser_idle;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push;

    // Slicer and FIFO handshake decisions.
    always_comb begin
        lvl_i      = slice($signed(bus.filt_i));
        lvl_q      = slice($signed(bus.filt_q));
        nibble     = {lvl_i, lvl_q};
        head       = mem_q[rd_ptr_q];
        ser_idle   = (bit_cnt_q == 2'd0);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
        // Pop decision uses the pre-write level: no bypass of an empty FIFO.
        pop        = bus.bit_req && ser_idle && !fifo_empty;
        // A full FIFO still accepts a write when a pop frees a slot this cycle.
        push       = bus.sym_valid && (!fifo_full || pop);
    end

    // Next state for slicer outputs, FIFO pointers/level and sticky flags.
    always_comb begin
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.sym_valid) begin
            sym_i_d = lvl_i;
            sym_q_d = lvl_q;
            if (!push) begin
                overflow_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (bus.bit_req && ser_idle && fifo_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Next state for the serializer: bit counter, shift register and output bit.
    always_comb begin
        signal_d       = signal_q;
        signal_valid_d = 1'b0;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;

        if (bus.bit_req) begin
            if (ser_idle) begin
                if (pop) begin
                    signal_d       = head[3];
                    shift_d        = head[2:0];
                    bit_cnt_d      = 2'd1;
                    signal_valid_d = 1'b1;
                end
            end else begin
                signal_d       = shift_q[2];
                shift_d        = {shift_q[1:0], 1'b0};
                // Wraps 3 -> 0 so the next request pops without a bubble.
                bit_cnt_d      = bit_cnt_q + 2'd1;
                signal_valid_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_signal or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            sym_i_q        <= 2'b00;
            sym_q_q        <= 2'b00;
            bit_cnt_q      <= 2'd0;
            shift_q        <= 3'b000;
            signal_q       <= 1'b0;
            signal_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            sym_i_q        <= sym_i_d;
            sym_q_q        <= sym_q_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            signal_q       <= signal_d;
            signal_valid_q <= signal_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset alone.
    always_ff @(posedge clk_signal) begin
        if (push) begin
            mem_q[wr_ptr_q] <= nibble;
        end
    end

    assign bus.signal       = signal_q;
    assign bus.signal_valid = signal_valid_q;
    assign bus.sym_i        = sym_i_q;
    assign bus.sym_q        = sym_q_q;
    assign bus.fifo_level   = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
